alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Shares one ALU and one 8-entry register file between NREQ independent requesters. A round-robin arbiter grants one operation per cycle. The granted operation reads its sources, executes, and writes its destination register at the issue edge. Each result is returned through a single held response channel tagged with the requester id. A clear sequencer zeroes the register file on command, one entry per cycle, and blocks issue while it runs.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, data width
NREG, 8, register count (power of 2); index width RW = log2(NREG)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  NREQ  per-requester operation valid
req_ready  output  NREQ  per-requester accept (at most one bit high)
req_op  input  3*NREQ  packed opcodes, requester i at [3i+2:3i]
req_rd  input  RW*NREQ  packed destination indices
req_rs1  input  RW*NREQ  packed source-1 indices
req_rs2  input  RW*NREQ  packed source-2 indices
req_imm  input  DW*NREQ  packed immediates
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  clog2(NREQ)  id of the requester that issued the result
rsp_data  output  DW  ALU result
clr_req  input  1  start register-file clear (single-cycle pulse)
clr_done  output  1  one-cycle pulse when the clear completes
busy  output  1  high while in CLEAR or while rsp_valid=1

Behaviour:
- Reset values:
  - state = RUN, rr_ptr = 0, all registers 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, clr_done = 0.
- FSM has two states, RUN and CLEAR.
- can_issue = (state==RUN) && !clr_req && (!rsp_valid || rsp_ready).
- Arbitration:
  - Search req_valid starting at rr_ptr, ascending with wrap.
  - The first set bit is granted g.
  - req_ready[g] = can_issue; all other req_ready bits are 0.
  - A handshake on g sets rr_ptr = (g+1) mod NREQ. With no handshake, rr_ptr holds.
  - A requester holds valid and its payload stable until ready.
- Execute on a handshake, combinationally from the current register contents:
  - a = reg[rs1], b = reg[rs2], sh = b[log2(DW)-1:0].
  - 0 add mod 2^DW; 1 sub mod 2^DW; 2 and; 3 or; 4 xor; 5 a<<sh; 6 a>>sh (logical); 7 imm.
- Issue edge actions:
  - reg[rd] <= result.
  - rsp_data <= result, rsp_id <= g, rsp_valid <= 1.
  - Because the write lands at this edge, the next-cycle issue sees the new value; no bypass is needed.
  - rd == rs1/rs2 reads the old value.
- Response channel:
  - rsp_valid, rsp_id and rsp_data stay stable while rsp_valid && !rsp_ready.
  - rsp_valid drops after rsp_ready with no new issue.
  - Accept and a new issue in the same cycle replace the response with no bubble, giving full throughput of 1 op/cycle.
- Clear sequence:
  - clr_req sampled in RUN moves to CLEAR with idx=0. clr_req has priority over a same-cycle grant (no req_ready that cycle).
  - In CLEAR: reg[idx] <= 0 and idx++ each cycle. The edge that writes idx NREG-1 returns to RUN.
  - clr_done is registered and is high exactly the first cycle back in RUN.
  - clr_req in CLEAR is ignored.
  - A pending response stays valid and acceptable during CLEAR and is not modified.
- Reset mid-operation (CLEAR or a held response) aborts to the reset values above. Partially cleared registers are fully zeroed by the reset.
- Width rules:
  - Overflow and borrow are discarded.
  - A shift amount of DW-1 is legal.
  - Shift bits above log2(DW) are ignored.

Test Plan:
- Basic sequence, req0 only, rsp_ready=1:
  - op7 imm=5 rd=1, then op7 imm=3 rd=2, then op0 rs1=1 rs2=2 rd=3.
  - Responses 5, 3, 8, all rsp_id=0, on consecutive cycles.
- Fairness: all four req_valid held high, rsp_ready=1.
  - Grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later.
  - Drop req1 mid-stream: the order skips 1.
- Back-pressure: response pending and rsp_ready=0 for 3 cycles.
  - All req_ready=0; rsp_data and rsp_id stable.
  - rsp_ready=1 with req2 valid: same-cycle accept and new issue, rsp_id=2 next cycle.
- Back-to-back dependency: op7 imm=0xFFFFFFFF rd=4, next cycle op0 rs1=4 rs2=4 rd=5.
  - Response 0xFFFFFFFE.
  - Then op1 rs1=5 rs2=4 → 0xFFFFFFFF.
- Shifts: reg1=1, reg2=0x25.
  - op5 rs1=1 rs2=2 → 0x20.
  - reg6=0x80000000, reg7=31: op6 rs1=6 rs2=7 → 1.
- Clear: all registers nonzero, clr_req pulse at cycle T with req0 valid.
  - req_ready=0 for cycles T..T+8; clr_done high in cycle T+9.
  - Then op0 rs1=1 rs2=2 → 0.
  - Repeat with rst asserted at T+4: clr_done never pulses; all registers read 0 afterwards.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one ALU and one register file
// between NREQ requesters, with a held tagged response channel and a
// one-entry-per-cycle register-file clear sequencer that blocks issue.
module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int NREG = 8,
  localparam int RW  = $clog2(NREG),
  localparam int IW  = $clog2(NREQ),
  localparam int SW  = $clog2(DW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [RW*NREQ-1:0] req_rd,
  input  logic [RW*NREQ-1:0] req_rs1,
  input  logic [RW*NREQ-1:0] req_rs2,
  input  logic [DW*NREQ-1:0] req_imm,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [DW-1:0]      rsp_data,
  input  logic               clr_req,
  output logic               clr_done,
  output logic               busy
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [RW-1:0] clr_idx;
  logic [DW-1:0] regs [NREG];

  // Per-requester views of the packed payload buses
  logic [2:0]    op_arr  [NREQ];
  logic [RW-1:0] rd_arr  [NREQ];
  logic [RW-1:0] rs1_arr [NREQ];
  logic [RW-1:0] rs2_arr [NREQ];
  logic [DW-1:0] imm_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]  = req_op[3*i +: 3];
    assign rd_arr[i]  = req_rd[RW*i +: RW];
    assign rs1_arr[i] = req_rs1[RW*i +: RW];
    assign rs2_arr[i] = req_rs2[RW*i +: RW];
    assign imm_arr[i] = req_imm[DW*i +: DW];
  end

  logic [IW-1:0] grant;
  logic          grant_found;
  logic          can_issue;
  logic          handshake;
  logic [IW-1:0] next_ptr;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap
  always_comb begin
    int cand;
    grant       = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      if (!grant_found && req_valid[cand]) begin
        grant       = IW'(cand);
        grant_found = 1'b1;
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // A pending clear request wins over any grant in the same cycle
  assign can_issue = (state == RUN) && !clr_req && (!rsp_valid || rsp_ready);
  assign handshake = can_issue && grant_found;
  assign next_ptr  = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
  assign busy      = (state == CLEAR) || rsp_valid;

  // Only the granted requester sees ready, and only when issue is possible
  always_comb begin
    req_ready = '0;
    if (handshake) begin
      req_ready[grant] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  logic [2:0]    op;
  logic [RW-1:0] rd;
  logic [DW-1:0] imm;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [SW-1:0] sh;
  logic [DW-1:0] result;

  // Operands come from the current contents; rd==rs reads the old value
  assign op  = op_arr[grant];
  assign rd  = rd_arr[grant];
  assign imm = imm_arr[grant];
  assign a   = regs[rs1_arr[grant]];
  assign b   = regs[rs2_arr[grant]];
  assign sh  = b[SW-1:0];

  // ALU: wrap-around arithmetic, shift amount taken from the low bits of b
  always_comb begin
    result = '0;
    case (op)
      3'd0:    result = a + b;
      3'd1:    result = a - b;
      3'd2:    result = a & b;
      3'd3:    result = a | b;
      3'd4:    result = a ^ b;
      3'd5:    result = a << sh;
      3'd6:    result = a >> sh;
      3'd7:    result = imm;
      default: result = '0;
    endcase
  end

  // Run/clear FSM with register file, arbiter pointer and response holding
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rr_ptr    <= '0;
      clr_idx   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      clr_done  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      clr_done <= 1'b0;
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end else begin
        rsp_valid <= rsp_valid;
      end
      case (state)
        RUN: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end else if (handshake) begin
            regs[rd]  <= result;
            rsp_data  <= result;
            rsp_id    <= grant;
            rsp_valid <= 1'b1;
            rr_ptr    <= next_ptr;
          end else begin
            state <= RUN;
          end
        end
        CLEAR: begin
          regs[clr_idx] <= '0;
          clr_idx       <= clr_idx + RW'(1);
          if (clr_idx == RW'(NREG - 1)) begin
            state    <= RUN;
            clr_done <= 1'b1;
          end else begin
            state <= CLEAR;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: vector table plus hand-written sequences,
// responses checked against a scoreboard queue of {id, data}.
module tb_alu_rr_scheduler;

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [11:0]  req_op;
  logic [11:0]  req_rd;
  logic [11:0]  req_rs1;
  logic [11:0]  req_rs2;
  logic [127:0] req_imm;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         clr_req;
  logic         clr_done;
  logic         busy;

  int  n_cmp  = 0;
  int  n_fail = 0;
  sb_t sbq[$];
  sb_t mon_e;

  alu_rr_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_payload(input int id, input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm);
    req_op[3*id +: 3]   = op;
    req_rd[3*id +: 3]   = rd;
    req_rs1[3*id +: 3]  = rs1;
    req_rs2[3*id +: 3]  = rs2;
    req_imm[32*id +: 32] = imm;
  endtask

  // Present one operation, wait (bounded) for its handshake, record expectation
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    set_payload(v.id, v.op, v.rd, v.rs1, v.rs2, v.imm);
    req_valid[v.id] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready[v.id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sbq.push_back('{2'(v.id), v.exp});
    end else begin
      chk("req_ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
  endtask

  // Scoreboard: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %h, expected none", rsp_id, rsp_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data", rsp_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  vec_t tbl[19];
  int   fair_exp[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
  logic [3:0] exp_rdy;
  bit   seen_done;

  initial begin
    tbl[0]  = '{0, 3'd7, 3'd1, 3'd0, 3'd0, 32'd5,        32'd5};
    tbl[1]  = '{0, 3'd7, 3'd2, 3'd0, 3'd0, 32'd3,        32'd3};
    tbl[2]  = '{0, 3'd0, 3'd3, 3'd1, 3'd2, 32'd0,        32'd8};
    tbl[3]  = '{0, 3'd7, 3'd4, 3'd0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4]  = '{0, 3'd0, 3'd5, 3'd4, 3'd4, 32'd0,        32'hFFFFFFFE};
    tbl[5]  = '{0, 3'd1, 3'd3, 3'd5, 3'd4, 32'd0,        32'hFFFFFFFF};
    tbl[6]  = '{0, 3'd7, 3'd1, 3'd0, 3'd0, 32'd1,        32'd1};
    tbl[7]  = '{0, 3'd7, 3'd2, 3'd0, 3'd0, 32'h25,       32'h25};
    tbl[8]  = '{0, 3'd5, 3'd3, 3'd1, 3'd2, 32'd0,        32'h20};
    tbl[9]  = '{0, 3'd7, 3'd6, 3'd0, 3'd0, 32'h80000000, 32'h80000000};
    tbl[10] = '{0, 3'd7, 3'd7, 3'd0, 3'd0, 32'd31,       32'd31};
    tbl[11] = '{0, 3'd6, 3'd0, 3'd6, 3'd7, 32'd0,        32'd1};
    tbl[12] = '{0, 3'd2, 3'd0, 3'd6, 3'd7, 32'd0,        32'd0};
    tbl[13] = '{0, 3'd3, 3'd0, 3'd6, 3'd7, 32'd0,        32'h8000001F};
    tbl[14] = '{0, 3'd4, 3'd0, 3'd5, 3'd4, 32'd0,        32'd1};
    tbl[15] = '{0, 3'd5, 3'd0, 3'd1, 3'd7, 32'd0,        32'h80000000};
    tbl[16] = '{0, 3'd0, 3'd7, 3'd7, 3'd7, 32'd0,        32'h3E};
    tbl[17] = '{0, 3'd3, 3'd0, 3'd7, 3'd7, 32'd0,        32'h3E};
    tbl[18] = '{0, 3'd1, 3'd0, 3'd1, 3'd2, 32'd0,        32'hFFFFFFDC};

    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_rd    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_imm   = '0;
    rsp_ready = 1'b1;
    clr_req   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_clr_done", 32'(clr_done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;

    // Fairness: all four valid, then req1 dropped after six grants
    for (int i = 0; i < 4; i++) begin
      set_payload(i, 3'd7, 3'd0, 3'd0, 3'd0, 32'h100 + 32'(i));
    end
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req_valid[1] = 1'b0;
      @(negedge clk);
      exp_rdy = 4'b0001 << fair_exp[k];
      chk("fair_ready", 32'(req_ready), 32'(exp_rdy));
      sbq.push_back('{2'(fair_exp[k]), 32'h100 + 32'(fair_exp[k])});
      @(posedge clk); #1;
    end
    req_valid = '0;

    // Back-pressure: hold a response for three cycles, then accept + issue
    set_payload(0, 3'd7, 3'd0, 3'd0, 3'd0, 32'hA5);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("bp_first_ready", 32'(req_ready), 32'h1);
    sbq.push_back('{2'd0, 32'hA5});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rsp_ready = 1'b0;
    set_payload(2, 3'd7, 3'd0, 3'd0, 3'd0, 32'h77);
    req_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_blocked", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'hA5);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_ready", 32'(req_ready), 32'h4);
    sbq.push_back('{2'd2, 32'h77});
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Vector table: basic, dependency, shifts, logic ops, rd==rs, borrow
    for (int i = 0; i < 19; i++) begin
      send(tbl[i]);
    end

    // Clear with req0 waiting: blocked for nine cycles, clr_done in the tenth
    clr_req = 1'b1;
    set_payload(0, 3'd0, 3'd3, 3'd1, 3'd2, 32'd0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("clr_ready_T", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    clr_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("clr_ready_blocked", 32'(req_ready), 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_done_early", 32'(clr_done), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    chk("clr_ready_after", 32'(req_ready), 32'h1);
    sbq.push_back('{2'd0, 32'd0});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("clr_done_one_cycle", 32'(clr_done), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send('{0, 3'd3, 3'(i), 3'(i), 3'(i), 32'd0, 32'd0});
    end

    // Refill, start a clear, then reset four cycles in
    for (int i = 0; i < 8; i++) begin
      send('{0, 3'd7, 3'(i), 3'd0, 3'd0, 32'(i + 1), 32'(i + 1)});
    end
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("clr2_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (clr_done) seen_done = 1'b1;
    end
    chk("clr2_no_done", 32'(seen_done), 32'd0);
    chk("clr2_busy_after_rst", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send('{0, 3'd3, 3'(i), 3'(i), 3'(i), 32'd0, 32'd0});
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
